// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - fixed-priority interrupt controller with global mask handshake
//
// Latches rising edges on irq_in as pending, selects the lowest pending index,
// requests service from the control unit and pulses mask_int / unmask_int
// around the handler so the comparator flag register can track flags[2].
//
// Optional feature macro: NMI_EN (source 0 becomes non-maskable).
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   irq_in      raw interrupt lines, synchronous to clk
//   flags       comparator flag register; bit 2 is the global mask (1 = masked)
//   int_ack     control unit accepts the outstanding request
//   reti        return-from-interrupt executed
//   int_req     registered interrupt request
//   int_id      registered index of the requested source
//   int_vector  registered handler address for int_id
//   mask_int    one-cycle pulse: set flags[2]
//   unmask_int  one-cycle pulse: clear flags[2]
//   pending     latched pending bits

module interrupt_controller #(
    parameter int          NUM_SRC   = 4,
    parameter logic [15:0] VEC_BASE  = 16'h0010,
    parameter int          VEC_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         irq_in,
    input  logic [15:0]                flags,
    input  logic                       int_ack,
    input  logic                       reti,
    output logic                       int_req,
    output logic [$clog2(NUM_SRC)-1:0] int_id,
    output logic [15:0]                int_vector,
    output logic                       mask_int,
    output logic                       unmask_int,
    output logic [NUM_SRC-1:0]         pending
);

    localparam int ID_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RESUME  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_vec;
    logic [ID_W-1:0]    sel;
    logic [15:0]        sel_vector;
    logic               any_pending;
    logic               masked;
    logic               ack_take;
    logic               start_req;
    logic               drop_req;

    logic               int_req_nxt;
    logic [ID_W-1:0]    int_id_nxt;
    logic [15:0]        int_vector_nxt;
    logic               mask_int_nxt;
    logic               unmask_int_nxt;

    logic               unused_flags;
    assign unused_flags = ^{flags[15:3], flags[1:0]};

    assign masked      = flags[2];
    assign any_pending = |pending;
    assign rise        = irq_in & ~irq_prev;
    assign ack_take    = (state == REQ) && int_ack;

    // Lowest pending index wins; scan from the top so index 0 is written last.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    assign sel_vector = VEC_BASE + (16'(sel) << VEC_SHIFT);

`ifdef NMI_EN
    assign start_req = pending[0] || (any_pending && !masked);
    assign drop_req  = masked && (int_id != '0);
`else
    assign start_req = any_pending && !masked;
    assign drop_req  = masked;
`endif

    always_comb begin
        clr_vec = '0;
        if (ack_take) begin
            clr_vec[int_id] = 1'b1;
        end
    end

    // The edge detector keeps sampling through reset, so a line that is
    // already high when reset releases is not mistaken for a fresh edge.
    // The set term is OR-ed after the clear so a same-cycle edge is kept.
    always_ff @(posedge clk) begin
        irq_prev <= irq_in;
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nxt = SERVICE;
                end else if (drop_req) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (reti) begin
                    state_nxt = RESUME;
                end
            end
            RESUME: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // id/vector only move on the IDLE->REQ transition, so a later
    // higher-priority arrival cannot re-select an outstanding request.
    always_comb begin
        int_req_nxt    = (state_nxt == REQ);
        int_id_nxt     = int_id;
        int_vector_nxt = int_vector;
        mask_int_nxt   = ack_take;
        unmask_int_nxt = (state == SERVICE) && reti;
        if ((state == IDLE) && start_req) begin
            int_id_nxt     = sel;
            int_vector_nxt = sel_vector;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_req    <= 1'b0;
            int_id     <= '0;
            int_vector <= VEC_BASE;
            mask_int   <= 1'b0;
            unmask_int <= 1'b0;
        end else begin
            int_req    <= int_req_nxt;
            int_id     <= int_id_nxt;
            int_vector <= int_vector_nxt;
            mask_int   <= mask_int_nxt;
            unmask_int <= unmask_int_nxt;
        end
    end

endmodule
